cmn_sram_arbiter_1rw: RTL and testbench

Shares one single-ported synchronous SRAM (1 read/write port, 1-cycle registered read, byte-enabled write) between `p_num_reqs` independent val/rdy requesters. Round-robin arbitration issues at most one SRAM access per cycle and returns one response per accepted request on that requester's response port. Sits between client engines and the synchronous SRAM macro in the common library.

---
 rtl/cmn_sram_arb_pkg.sv | 16 +
 rtl/cmn_round_robin_arbiter.sv | 50 +++++
 rtl/cmn_sram_arbiter_1rw.sv | 134 +++++++++++++
 tb/tb_cmn_sram_arbiter_1rw.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmn_sram_arb_pkg.sv
// Shared types for the single-port SRAM arbiter: per-requester FSM state
// encoding and request-type constants.
package cmn_sram_arb_pkg;

    localparam int c_state_nbits = 2;

    typedef enum logic [c_state_nbits-1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_RESP   = 2'd2
    } req_state_e;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/cmn_round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// priority pointer; the pointer moves past the winner on every grant.
module cmn_round_robin_arbiter #(
    parameter int p_num_reqs = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [p_num_reqs-1:0] req,
    output logic [p_num_reqs-1:0] grant
);

    localparam int c_ptr_nbits = $clog2(p_num_reqs);

    logic [c_ptr_nbits-1:0] ptr_q;
    logic [c_ptr_nbits-1:0] ptr_d;
    logic [c_ptr_nbits-1:0] idx;
    logic                   found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Scan from the pointer, wrapping at p_num_reqs (need not be a power of 2).
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        if (en) begin
            for (int k = 0; k < p_num_reqs; k++) begin
                if (int'(ptr_q) + k >= p_num_reqs) begin
                    idx = c_ptr_nbits'(int'(ptr_q) + k - p_num_reqs);
                end else begin
                    idx = c_ptr_nbits'(int'(ptr_q) + k);
                end
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_d      = (int'(idx) == p_num_reqs - 1) ? '0 : idx + c_ptr_nbits'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cmn_sram_arbiter_1rw.sv
// Shares one 1RW synchronous SRAM between p_num_reqs val/rdy requesters with
// round-robin arbitration; one outstanding request and one response each.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no outstanding request; eligible for a grant when req_val
// ST_ISSUED | SRAM accessed last cycle; read data captured this cycle
// ST_RESP   | resp_val high, resp_data held until resp_val && resp_rdy
module cmn_sram_arbiter_1rw
    import cmn_sram_arb_pkg::*;
#(
    parameter  int p_num_reqs    = 2,
    parameter  int p_data_nbits  = 32,
    parameter  int p_num_entries = 256,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                                     clk,
    input  logic                                     reset,

    input  logic [p_num_reqs-1:0]                    req_val,
    output logic [p_num_reqs-1:0]                    req_rdy,
    input  logic [p_num_reqs-1:0]                    req_wen,
    input  logic [p_num_reqs-1:0][c_addr_nbits-1:0]  req_addr,
    input  logic [p_num_reqs-1:0][c_data_nbytes-1:0] req_byte_en,
    input  logic [p_num_reqs-1:0][p_data_nbits-1:0]  req_data,

    output logic [p_num_reqs-1:0]                    resp_val,
    input  logic [p_num_reqs-1:0]                    resp_rdy,
    output logic [p_num_reqs-1:0][p_data_nbits-1:0]  resp_data,

    output logic                                     sram_read_en,
    output logic [c_addr_nbits-1:0]                  sram_read_addr,
    input  logic [p_data_nbits-1:0]                  sram_read_data,

    output logic                                     sram_write_en,
    output logic [c_data_nbytes-1:0]                 sram_write_byte_en,
    output logic [c_addr_nbits-1:0]                  sram_write_addr,
    output logic [p_data_nbits-1:0]                  sram_write_data
);

    localparam int c_sel_nbits = $clog2(p_num_reqs);

    req_state_e                           state_q [p_num_reqs];
    req_state_e                           state_d [p_num_reqs];
    logic [p_num_reqs-1:0]                wen_q;
    logic [p_num_reqs-1:0][p_data_nbits-1:0] resp_data_q;
    logic [p_num_reqs-1:0]                eligible;
    logic [p_num_reqs-1:0]                grant;
    logic [c_sel_nbits-1:0]               sel;
    logic                                 any_grant;

    // Gating with reset keeps req_rdy and the SRAM enables low while reset is held.
    cmn_round_robin_arbiter #(
        .p_num_reqs (p_num_reqs)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (~reset),
        .req   (eligible),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < p_num_reqs; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < p_num_reqs; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < p_num_reqs; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_IDLE:   if (grant[i])    state_d[i] = ST_ISSUED;
                ST_ISSUED:                  state_d[i] = ST_RESP;
                ST_RESP:   if (resp_rdy[i]) state_d[i] = ST_IDLE;
                default:                    state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        eligible = '0;
        resp_val = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            eligible[i] = req_val[i] && (state_q[i] == ST_IDLE);
            resp_val[i] = (state_q[i] == ST_RESP);
        end
    end

    // The SRAM read data is valid in the ISSUED cycle only; capture it then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wen_q       <= '0;
            resp_data_q <= '0;
        end else begin
            for (int i = 0; i < p_num_reqs; i++) begin
                if (grant[i]) begin
                    wen_q[i] <= req_wen[i];
                end
                if (state_q[i] == ST_ISSUED) begin
                    resp_data_q[i] <= (wen_q[i] == REQ_WRITE) ? '0 : sram_read_data;
                end
            end
        end
    end

    assign resp_data = resp_data_q;
    assign req_rdy   = grant;

    always_comb begin
        sel = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (grant[i]) begin
                sel = c_sel_nbits'(i);
            end
        end
    end

    assign any_grant          = |grant;
    assign sram_read_en       = any_grant && (req_wen[sel] == REQ_READ);
    assign sram_write_en      = any_grant && (req_wen[sel] == REQ_WRITE);
    assign sram_read_addr     = req_addr[sel];
    assign sram_write_addr    = req_addr[sel];
    assign sram_write_byte_en = req_byte_en[sel];
    assign sram_write_data    = req_data[sel];

endmodule

// File: tb/tb_cmn_sram_arbiter_1rw.sv
// Directed bench for cmn_sram_arbiter_1rw with a behavioural SRAM and a
// scoreboard of expected responses filled at request acceptance.
module tb_cmn_sram_arbiter_1rw;

    typedef struct packed {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [1:0]       req_val;
    logic [1:0]       req_rdy;
    logic [1:0]       req_wen;
    logic [1:0][7:0]  req_addr;
    logic [1:0][3:0]  req_byte_en;
    logic [1:0][31:0] req_data;
    logic [1:0]       resp_val;
    logic [1:0]       resp_rdy;
    logic [1:0][31:0] resp_data;
    logic             sram_read_en;
    logic [7:0]       sram_read_addr;
    logic [31:0]      sram_read_data;
    logic             sram_write_en;
    logic [3:0]       sram_write_byte_en;
    logic [7:0]       sram_write_addr;
    logic [31:0]      sram_write_data;

    logic [31:0] mem       [256];
    logic [31:0] model_mem [256];
    exp_t        q0[$];
    exp_t        q1[$];
    logic [1:0]  prev_rv = '0;
    int          cyc     = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    cmn_sram_arbiter_1rw #(
        .p_num_reqs    (2),
        .p_data_nbits  (32),
        .p_num_entries (256)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_val            (req_val),
        .req_rdy            (req_rdy),
        .req_wen            (req_wen),
        .req_addr           (req_addr),
        .req_byte_en        (req_byte_en),
        .req_data           (req_data),
        .resp_val           (resp_val),
        .resp_rdy           (resp_rdy),
        .resp_data          (resp_data),
        .sram_read_en       (sram_read_en),
        .sram_read_addr     (sram_read_addr),
        .sram_read_data     (sram_read_data),
        .sram_write_en      (sram_write_en),
        .sram_write_byte_en (sram_write_byte_en),
        .sram_write_addr    (sram_write_addr),
        .sram_write_data    (sram_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 1RW SRAM: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (sram_write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_write_byte_en[b]) mem[sram_write_addr][b*8 +: 8] <= sram_write_data[b*8 +: 8];
            end
        end
        if (sram_read_en) sram_read_data <= mem[sram_read_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Scoreboard: push at acceptance from the reference memory, compare on response.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q0.delete();
            q1.delete();
            prev_rv = '0;
        end else begin
            if (sram_read_en || sram_write_en)
                chk("sram_en_exclusive", 32'(sram_read_en & sram_write_en), 32'd0);
            for (int i = 0; i < 2; i++) begin
                if (req_val[i] && req_rdy[i]) begin
                    e.cyc = cyc;
                    if (req_wen[i]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (req_byte_en[i][b]) model_mem[req_addr[i]][b*8 +: 8] = req_data[i][b*8 +: 8];
                        end
                        e.data = 32'd0;
                    end else begin
                        e.data = model_mem[req_addr[i]];
                    end
                    if (i == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (resp_val[i]) begin
                    int sz;
                    sz = (i == 0) ? q0.size() : q1.size();
                    chk("resp_has_request", 32'(sz > 0), 32'd1);
                    if (sz > 0) begin
                        e = (i == 0) ? q0[0] : q1[0];
                        chk("resp_data", resp_data[i], e.data);
                        if (!prev_rv[i]) chk("resp_latency", 32'(cyc - e.cyc), 32'd2);
                        if (resp_rdy[i]) begin
                            if (i == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                        end
                    end
                end
            end
            prev_rv = resp_val;
        end
    end

    task automatic send(input int i, input logic wen, input logic [7:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_wen[i]     = wen;
        req_addr[i]    = addr;
        req_byte_en[i] = be;
        req_data[i]    = data;
        req_val[i]     = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_rdy[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_in_time", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_val[i] = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && resp_val == 2'b00) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", 32'(done), 32'd1);
    endtask

    initial begin
        int gseq[$];
        int hold;
        int n0;
        logic ok;

        for (int a = 0; a < 256; a++) begin
            mem[a]       = '0;
            model_mem[a] = '0;
        end
        reset = 1'b1;
        req_val = '0; req_wen = '0; req_addr = '0; req_byte_en = '0; req_data = '0;
        resp_rdy = 2'b11;

        // Reset state
        repeat (2) @(posedge clk);
        #1 req_val = 2'b11;
        #1;
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_resp_val", 32'(resp_val), 32'd0);
        chk("rst_sram_en", 32'({sram_read_en, sram_write_en}), 32'd0);
        req_val = 2'b00;
        @(posedge clk); #1 reset = 1'b0;
        #1;
        chk("rst_resp_data0", resp_data[0], 32'd0);
        chk("rst_resp_data1", resp_data[1], 32'd0);

        // Single write then read
        send(0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
        @(negedge clk); @(negedge clk);
        chk("wr_resp_val", 32'(resp_val[0]), 32'd1);
        chk("wr_resp_data", resp_data[0], 32'd0);
        drain();
        send(0, 1'b0, 8'h10, 4'h0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("rd_resp_val", 32'(resp_val[0]), 32'd1);
        chk("rd_resp_data", resp_data[0], 32'hDEADBEEF);
        drain();

        // Byte enables
        send(0, 1'b1, 8'h20, 4'hF, 32'h11223344);
        drain();
        send(0, 1'b1, 8'h20, 4'h5, 32'hAABBCCDD);
        drain();
        send(1, 1'b0, 8'h20, 4'h0, 32'h0);
        @(negedge clk); @(negedge clk);
        chk("byte_en_data", resp_data[1], 32'h11BB33DD);
        drain();

        // Contention from reset: grants must alternate starting with req0
        @(posedge clk); #1 reset = 1'b1;
        req_wen = 2'b01;
        req_addr[0] = 8'h40; req_byte_en[0] = 4'hF; req_data[0] = 32'hCAFE0001;
        req_addr[1] = 8'h40;
        req_val = 2'b11;
        @(posedge clk); #1 reset = 1'b0;
        for (int t = 0; t < 13; t++) begin
            @(negedge clk);
            chk("cont_onehot", 32'(req_rdy == 2'b11), 32'd0);
            if (req_rdy[0]) gseq.push_back(0);
            if (req_rdy[1]) gseq.push_back(1);
        end
        @(posedge clk); #1 req_val = 2'b00;
        chk("cont_grant_count", 32'(gseq.size() >= 8), 32'd1);
        for (int k = 0; k < gseq.size(); k++) chk("cont_grant_order", 32'(gseq[k]), 32'(k % 2));
        drain();

        // Backpressure on requester 1 while requester 0 keeps being served
        @(posedge clk); #1;
        req_wen = 2'b00;
        req_addr[1] = 8'h10;
        req_addr[0] = 8'h20;
        resp_rdy[1] = 1'b0;
        req_val[1]  = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (req_rdy[1]) begin ok = 1'b1; break; end
        end
        chk("bp_first_accept", 32'(ok), 32'd1);
        @(posedge clk); #1 req_val[0] = 1'b1;
        hold = 0;
        n0   = 0;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            chk("bp_rdy1_low", 32'(req_rdy[1]), 32'd0);
            if (resp_val[1]) begin
                hold++;
                chk("bp_data_stable", resp_data[1], 32'hDEADBEEF);
            end
            if (req_rdy[0]) n0++;
        end
        chk("bp_hold_cycles", 32'(hold), 32'd6);
        chk("bp_req0_served", 32'(n0 >= 2), 32'd1);
        @(posedge clk); #1 resp_rdy[1] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (req_rdy[1]) begin ok = 1'b1; break; end
        end
        chk("bp_reaccept", 32'(ok), 32'd1);
        @(posedge clk); #1 req_val = 2'b00;
        drain();

        // Cross-requester read-after-write in consecutive cycles
        @(posedge clk); #1;
        req_wen[0] = 1'b1; req_addr[0] = 8'h03; req_byte_en[0] = 4'hF; req_data[0] = 32'h5A5A5A5A;
        req_val[0] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (req_rdy[0]) begin ok = 1'b1; break; end
        end
        chk("raw_wr_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_val[0] = 1'b0;
        req_wen[1] = 1'b0; req_addr[1] = 8'h03; req_val[1] = 1'b1;
        @(negedge clk);
        chk("raw_rd_accept", 32'(req_rdy[1]), 32'd1);
        @(posedge clk); #1 req_val[1] = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("raw_resp_val", 32'(resp_val[1]), 32'd1);
        chk("raw_resp_data", resp_data[1], 32'h5A5A5A5A);
        drain();

        // Reset mid-operation with the pointer moved off 0
        resp_rdy[0] = 1'b0;
        send(0, 1'b0, 8'h03, 4'h0, 32'h0);
        ok = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (resp_val[0]) begin ok = 1'b1; break; end
        end
        chk("mid_resp_seen", 32'(ok), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_resp_val_drop", 32'(resp_val), 32'd0);
        @(posedge clk); #1;
        req_wen = 2'b00;
        req_val = 2'b11;
        resp_rdy = 2'b11;
        #1 chk("mid_rst_req_rdy", 32'(req_rdy), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        #1 chk("mid_ptr_reset", 32'(req_rdy), 32'd1);
        @(posedge clk); #1 req_val = 2'b00;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
